// File: rtl/uart_tx_gen2.sv
// uart_tx_gen2 : buffered UART transmitter.
//
// Characters pushed through wr_en/wdata are stored in a FIFO_DEPTH-entry FIFO.
// A frame FSM then serialises them LSB-first on txd. Each frame has a start
// bit, 5..8 data bits, an optional parity bit (even/odd/stick) and 1 or 2 stop
// bits. Each serial bit lasts OVERSAMPLE bclk ticks.
//
// Ports
//   clk, resetn        system clock, asynchronous active-low reset
//   bclk               baud tick, one clk wide
//   tx_en              transmitter enable (gates pushes and frame starts)
//   wr_en, wdata       FIFO push request and character
//   char_len           data length select (DATA_W-3+char_len bits)
//   parity_en, parity_type, stick_par, stop2   frame format
//   brk                break request (txd forced low while idle)
//   fifo_flush         discard FIFO contents
//   tx_thr_val         FIFO threshold select
//   txd                registered serial output
//   tx_busy, tx_bclk_en  frame in progress
//   fifo_empty, fifo_full, fifo_level, tx_thr   FIFO status
//   wr_overflow        pulse when a push is dropped on a full FIFO
//   tx_done            pulse at the end of each frame
module uart_tx_gen2 #(
    parameter int FIFO_DEPTH = 16,
    parameter int DATA_W     = 8,
    parameter int OVERSAMPLE = 16,
    localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              bclk,
    input  logic              tx_en,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wdata,
    input  logic [1:0]        char_len,
    input  logic              parity_en,
    input  logic              parity_type,
    input  logic              stick_par,
    input  logic              stop2,
    input  logic              brk,
    input  logic              fifo_flush,
    input  logic [1:0]        tx_thr_val,
    output logic              txd,
    output logic              tx_busy,
    output logic              tx_bclk_en,
    output logic              fifo_empty,
    output logic              fifo_full,
    output logic [LVL_W-1:0]  fifo_level,
    output logic              tx_thr,
    output logic              wr_overflow,
    output logic              tx_done
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int IDX_W = $clog2(DATA_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [LVL_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  thr_lim;
    logic              push, pop;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [1:0]        len_q, len_d;
    logic              par_en_q, par_en_d, par_type_q, par_type_d;
    logic              stick_q, stick_d, stop2_q, stop2_d;
    logic              txd_q, txd_d, done_q, done_d, ovf_q, ovf_d;
    logic              bit_end, par_bit;
    logic [IDX_W-1:0]  last_idx;

    // FIFO status: pointers carry one extra wrap bit so full and empty differ.
    always_comb begin
        fifo_empty = (wr_ptr_q == rd_ptr_q);
        fifo_full  = (wr_ptr_q[LVL_W-1] != rd_ptr_q[LVL_W-1]) &&
                     (wr_ptr_q[LVL_W-2:0] == rd_ptr_q[LVL_W-2:0]);
        fifo_level = wr_ptr_q - rd_ptr_q;
        case (tx_thr_val)
            2'b00:   thr_lim = LVL_W'(FIFO_DEPTH);
            2'b01:   thr_lim = LVL_W'(FIFO_DEPTH * 7 / 8);
            2'b10:   thr_lim = LVL_W'(FIFO_DEPTH * 3 / 4);
            default: thr_lim = LVL_W'(FIFO_DEPTH / 2);
        endcase
        tx_thr = (fifo_level < thr_lim);
    end

    // Push/pop qualification; a flush overrides both in the same cycle.
    always_comb begin
        push     = wr_en & tx_en & ~fifo_full & ~fifo_flush;
        pop      = (state_q == S_IDLE) & tx_en & ~fifo_empty & ~brk & ~fifo_flush;
        ovf_d    = wr_en & tx_en & fifo_full;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (fifo_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + LVL_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + LVL_W'(1);
            end
        end
    end

    // Storage array needs no reset; only the pointers define its contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[LVL_W-2:0]] <= wdata;
        end
    end

    // Parity over the latched data length only; bits above it are ignored.
    always_comb begin
        last_idx = IDX_W'(DATA_W - 4) + IDX_W'(len_q);
        par_bit  = 1'b0;
        for (int i = 0; i < DATA_W; i++) begin
            if (IDX_W'(i) <= last_idx) begin
                par_bit = par_bit ^ shift_q[i];
            end
        end
        if (stick_q) begin
            par_bit = par_type_q;
        end else if (par_type_q) begin
            par_bit = ~par_bit;
        end
    end

    // Frame FSM. The tick counter only advances on bclk and a bit ends on the
    // tick that completes OVERSAMPLE ticks. Frame format is latched at the pop
    // so that input changes mid-frame cannot corrupt the character.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        len_d      = len_q;
        par_en_d   = par_en_q;
        par_type_d = par_type_q;
        stick_d    = stick_q;
        stop2_d    = stop2_q;
        done_d     = 1'b0;
        bit_end    = bclk && (cnt_q == CNT_W'(OVERSAMPLE - 1));

        if (state_q != S_IDLE && bclk) begin
            cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    shift_d    = mem_q[rd_ptr_q[LVL_W-2:0]];
                    len_d      = char_len;
                    par_en_d   = parity_en;
                    par_type_d = parity_type;
                    stick_d    = stick_par;
                    stop2_d    = stop2;
                    cnt_d      = '0;
                    idx_d      = '0;
                    state_d    = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (idx_q == last_idx) begin
                        idx_d   = '0;
                        state_d = par_en_q ? S_PARITY : S_STOP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                // idx_q counts stop bits already sent
                if (bit_end) begin
                    if (stop2_q && idx_q == '0) begin
                        idx_d = IDX_W'(1);
                    end else begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // txd is registered from the next-state view so the start bit appears
    // the cycle after the pop; an idle line shows the break request.
    always_comb begin
        case (state_d)
            S_START:  txd_d = 1'b0;
            S_DATA:   txd_d = shift_d[idx_d];
            S_PARITY: txd_d = par_bit;
            S_STOP:   txd_d = 1'b1;
            default:  txd_d = ~brk;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            state_q    <= S_IDLE;
            shift_q    <= '0;
            cnt_q      <= '0;
            idx_q      <= '0;
            len_q      <= '0;
            par_en_q   <= 1'b0;
            par_type_q <= 1'b0;
            stick_q    <= 1'b0;
            stop2_q    <= 1'b0;
            txd_q      <= 1'b1;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            state_q    <= state_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            len_q      <= len_d;
            par_en_q   <= par_en_d;
            par_type_q <= par_type_d;
            stick_q    <= stick_d;
            stop2_q    <= stop2_d;
            txd_q      <= txd_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
        end
    end

    assign txd         = txd_q;
    assign tx_busy     = (state_q != S_IDLE);
    assign tx_bclk_en  = tx_busy;
    assign wr_overflow = ovf_q;
    assign tx_done     = done_q;

endmodule

// File: tb/tb_uart_tx_gen2.sv
// tb_uart_tx_gen2 : self-checking bench for uart_tx_gen2.
//
// Every push computes the expected serial frame from the current format
// inputs and queues it; a receiver task pops the queue and compares the
// sampled line, frame duration, tx_done pulse and inter-frame gap.
module tb_uart_tx_gen2;

    localparam int FIFO_DEPTH = 16;
    localparam int DATA_W     = 8;
    localparam int OVERSAMPLE = 16;
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;
    localparam int BCLK_DIV   = 2;

    logic             clk = 1'b0;
    logic             resetn;
    logic             bclk = 1'b0;
    logic             tx_en, wr_en;
    logic [7:0]       wdata;
    logic [1:0]       char_len;
    logic             parity_en, parity_type, stick_par, stop2, brk, fifo_flush;
    logic [1:0]       tx_thr_val;
    logic             txd, tx_busy, tx_bclk_en, fifo_empty, fifo_full, tx_thr;
    logic [LVL_W-1:0] fifo_level;
    logic             wr_overflow, tx_done;

    typedef struct {
        logic [15:0] bits;
        int          nbits;
    } frame_t;

    frame_t sb_q[$];
    int     checks_total  = 0;
    int     checks_passed = 0;
    int     tick_cnt      = 0;
    int     done_cnt      = 0;
    int     ovf_cnt       = 0;
    int     div_cnt       = 0;

    uart_tx_gen2 #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .DATA_W     (DATA_W),
        .OVERSAMPLE (OVERSAMPLE)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .bclk        (bclk),
        .tx_en       (tx_en),
        .wr_en       (wr_en),
        .wdata       (wdata),
        .char_len    (char_len),
        .parity_en   (parity_en),
        .parity_type (parity_type),
        .stick_par   (stick_par),
        .stop2       (stop2),
        .brk         (brk),
        .fifo_flush  (fifo_flush),
        .tx_thr_val  (tx_thr_val),
        .txd         (txd),
        .tx_busy     (tx_busy),
        .tx_bclk_en  (tx_bclk_en),
        .fifo_empty  (fifo_empty),
        .fifo_full   (fifo_full),
        .fifo_level  (fifo_level),
        .tx_thr      (tx_thr),
        .wr_overflow (wr_overflow),
        .tx_done     (tx_done)
    );

    always #5 clk = ~clk;

    // Free-running baud tick, one clk wide, every BCLK_DIV clocks.
    always @(negedge clk) begin
        if (div_cnt == BCLK_DIV - 1) begin
            bclk    = 1'b1;
            div_cnt = 0;
        end else begin
            bclk    = 1'b0;
            div_cnt = div_cnt + 1;
        end
    end

    // Event counters sampled on the active edge.
    always @(posedge clk) begin
        if (bclk)        tick_cnt <= tick_cnt + 1;
        if (tx_done)     done_cnt <= done_cnt + 1;
        if (wr_overflow) ovf_cnt  <= ovf_cnt + 1;
    end

    // Push one character; when score is set the expected frame is queued.
    task automatic push_byte(input logic [7:0] d, input bit score);
        frame_t f;
        int     len;
        int     idx;
        logic   p;
        len    = 5 + int'(char_len);
        f.bits = '0;
        idx    = 1;
        for (int i = 0; i < len; i++) begin
            f.bits[idx] = d[i];
            idx++;
        end
        if (parity_en) begin
            p = 1'b0;
            for (int i = 0; i < len; i++) p = p ^ d[i];
            if (stick_par)        p = parity_type;
            else if (parity_type) p = ~p;
            f.bits[idx] = p;
            idx++;
        end
        f.bits[idx] = 1'b1;
        idx++;
        if (stop2) begin
            f.bits[idx] = 1'b1;
            idx++;
        end
        f.nbits = idx;
        wdata = d;
        wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
        if (score) sb_q.push_back(f);
    endtask

    // Receive one frame and compare it with the head of the scoreboard.
    task automatic rx_check(input string name, input int exp_gap);
        frame_t      exp;
        logic [15:0] got;
        int          base, waited, gap;
        if (sb_q.size() == 0) begin
            $display("[TB] FAIL %s: scoreboard empty, got frame request, required queued frame", name);
            checks_total++;
            return;
        end
        exp = sb_q.pop_front();
        gap = 0;
        while (tx_busy !== 1'b1) begin
            @(negedge clk);
            gap++;
            if (gap > 3000) begin
                $display("[TB] FAIL %s_start: tx_busy=%b, required 1 within 3000 cycles", name, tx_busy);
                checks_total++;
                return;
            end
        end
        base = tick_cnt;
        got  = '0;
        for (int b = 0; b < exp.nbits; b++) begin
            waited = 0;
            while (tick_cnt - base < OVERSAMPLE * b + OVERSAMPLE / 2) begin
                @(negedge clk);
                waited++;
                if (waited > 200) begin
                    $display("[TB] FAIL %s_tick: ticks=%0d, required %0d", name, tick_cnt - base, OVERSAMPLE * b + OVERSAMPLE / 2);
                    checks_total++;
                    return;
                end
            end
            got[b] = txd;
        end
        waited = 0;
        while (tx_busy !== 1'b0 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        checks_total++;
        if (got !== exp.bits) $display("[TB] FAIL %s_bits: got %b, required %b", name, got, exp.bits);
        else checks_passed++;
        checks_total++;
        if (tick_cnt - base !== exp.nbits * OVERSAMPLE)
            $display("[TB] FAIL %s_len: got %0d ticks, required %0d", name, tick_cnt - base, exp.nbits * OVERSAMPLE);
        else checks_passed++;
        checks_total++;
        if (tx_done !== 1'b1) $display("[TB] FAIL %s_done: tx_done=%b, required 1", name, tx_done);
        else checks_passed++;
        if (exp_gap >= 0) begin
            checks_total++;
            if (gap !== exp_gap) $display("[TB] FAIL %s_gap: got %0d idle cycles, required %0d", name, gap, exp_gap);
            else checks_passed++;
        end
    endtask

    task automatic set_fmt(input logic [1:0] cl, input logic pe, input logic pt,
                           input logic sp, input logic s2);
        char_len    = cl;
        parity_en   = pe;
        parity_type = pt;
        stick_par   = sp;
        stop2       = s2;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        tx_en = 1'b1; wr_en = 1'b0; wdata = '0; brk = 1'b0; fifo_flush = 1'b0;
        tx_thr_val = 2'b00;
        set_fmt(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        checks_total += 9;
        if (txd !== 1'b1)         $display("[TB] FAIL rst_txd: got %b, required 1", txd); else checks_passed++;
        if (tx_busy !== 1'b0)     $display("[TB] FAIL rst_busy: got %b, required 0", tx_busy); else checks_passed++;
        if (tx_bclk_en !== 1'b0)  $display("[TB] FAIL rst_bclk_en: got %b, required 0", tx_bclk_en); else checks_passed++;
        if (fifo_empty !== 1'b1)  $display("[TB] FAIL rst_empty: got %b, required 1", fifo_empty); else checks_passed++;
        if (fifo_full !== 1'b0)   $display("[TB] FAIL rst_full: got %b, required 0", fifo_full); else checks_passed++;
        if (fifo_level !== '0)    $display("[TB] FAIL rst_level: got %0d, required 0", fifo_level); else checks_passed++;
        if (tx_thr !== 1'b1)      $display("[TB] FAIL rst_thr: got %b, required 1", tx_thr); else checks_passed++;
        if (wr_overflow !== 1'b0) $display("[TB] FAIL rst_ovf: got %b, required 0", wr_overflow); else checks_passed++;
        if (tx_done !== 1'b0)     $display("[TB] FAIL rst_done: got %b, required 0", tx_done); else checks_passed++;
        resetn = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // 8N1 with format inputs and tx_en disturbed mid-frame.
    task automatic test_8n1();
        int d0;
        d0 = done_cnt;
        set_fmt(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        push_byte(8'h55, 1'b1);
        fork
            rx_check("8n1", -1);
            begin
                repeat (80) @(negedge clk);
                set_fmt(2'b00, 1'b1, 1'b1, 1'b0, 1'b1);
                tx_en = 1'b0;
            end
        join
        tx_en = 1'b1;
        set_fmt(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        checks_total++;
        if (done_cnt - d0 !== 1) $display("[TB] FAIL 8n1_done_cnt: got %0d pulses, required 1", done_cnt - d0);
        else checks_passed++;
    endtask

    task automatic test_7e2();
        set_fmt(2'b10, 1'b1, 1'b0, 1'b0, 1'b1);
        push_byte(8'h41, 1'b1);
        rx_check("7e2", -1);
    endtask

    task automatic test_parity();
        set_fmt(2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
        push_byte(8'h1F, 1'b1);
        rx_check("5o1", -1);
        set_fmt(2'b11, 1'b1, 1'b1, 1'b1, 1'b0);
        push_byte(8'h00, 1'b1);
        rx_check("8s1", -1);
    endtask

    task automatic test_break();
        @(negedge clk);
        brk = 1'b1;
        @(negedge clk);
        checks_total += 2;
        if (txd !== 1'b0) $display("[TB] FAIL brk_low: got %b, required 0", txd); else checks_passed++;
        if (tx_busy !== 1'b0) $display("[TB] FAIL brk_busy: got %b, required 0", tx_busy); else checks_passed++;
        brk = 1'b0;
        @(negedge clk);
        checks_total++;
        if (txd !== 1'b1) $display("[TB] FAIL brk_release: got %b, required 1", txd); else checks_passed++;
    endtask

    task automatic test_push_gating();
        int o0;
        o0 = ovf_cnt;
        tx_en = 1'b0;
        push_byte(8'hAA, 1'b0);
        @(negedge clk);
        tx_en = 1'b1;
        checks_total += 2;
        if (fifo_level !== '0) $display("[TB] FAIL gate_level: got %0d, required 0", fifo_level); else checks_passed++;
        if (ovf_cnt !== o0) $display("[TB] FAIL gate_ovf: got %0d pulses, required 0", ovf_cnt - o0); else checks_passed++;
    endtask

    task automatic test_overflow();
        int o0;
        set_fmt(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        brk = 1'b1;
        o0 = ovf_cnt;
        for (int i = 1; i <= 16; i++) push_byte(8'(i), 1'b1);
        checks_total += 3;
        if (fifo_full !== 1'b1) $display("[TB] FAIL ovf_full: got %b, required 1", fifo_full); else checks_passed++;
        if (fifo_level !== LVL_W'(16)) $display("[TB] FAIL ovf_level16: got %0d, required 16", fifo_level); else checks_passed++;
        if (wr_overflow !== 1'b0) $display("[TB] FAIL ovf_early: got %b, required 0", wr_overflow); else checks_passed++;
        push_byte(8'd17, 1'b0);
        checks_total += 3;
        if (wr_overflow !== 1'b1) $display("[TB] FAIL ovf_pulse: got %b, required 1", wr_overflow); else checks_passed++;
        if (fifo_level !== LVL_W'(16)) $display("[TB] FAIL ovf_level: got %0d, required 16", fifo_level); else checks_passed++;
        if (txd !== 1'b0) $display("[TB] FAIL ovf_brk_txd: got %b, required 0", txd); else checks_passed++;
        @(negedge clk);
        checks_total += 2;
        if (wr_overflow !== 1'b0) $display("[TB] FAIL ovf_single: got %b, required 0", wr_overflow); else checks_passed++;
        if (ovf_cnt - o0 !== 1) $display("[TB] FAIL ovf_count: got %0d, required 1", ovf_cnt - o0); else checks_passed++;
        brk = 1'b0;
        rx_check("ovf_frame1", -1);
        for (int i = 2; i <= 16; i++) rx_check($sformatf("ovf_frame%0d", i), 1);
    endtask

    task automatic test_threshold_flush();
        int thr_tab[4];
        thr_tab[0] = FIFO_DEPTH;
        thr_tab[1] = FIFO_DEPTH * 7 / 8;
        thr_tab[2] = FIFO_DEPTH * 3 / 4;
        thr_tab[3] = FIFO_DEPTH / 2;
        set_fmt(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        brk = 1'b1;
        for (int n = 1; n <= 16; n++) begin
            push_byte(8'(8'hA0 + n), n == 1);
            if (n == 7 || n == 8 || n == 12 || n == 14 || n == 16) begin
                for (int v = 0; v < 4; v++) begin
                    tx_thr_val = 2'(v);
                    #1;
                    checks_total++;
                    if (tx_thr !== (n < thr_tab[v]))
                        $display("[TB] FAIL thr_l%0d_v%0d: got %b, required %b", n, v, tx_thr, n < thr_tab[v]);
                    else checks_passed++;
                end
            end
        end
        tx_thr_val = 2'b00;
        @(negedge clk);
        brk = 1'b0;
        fork
            rx_check("flush_frame", -1);
            begin
                repeat (100) @(negedge clk);
                fifo_flush = 1'b1;
                @(negedge clk);
                fifo_flush = 1'b0;
                checks_total += 3;
                if (fifo_level !== '0) $display("[TB] FAIL flush_level: got %0d, required 0", fifo_level); else checks_passed++;
                if (fifo_empty !== 1'b1) $display("[TB] FAIL flush_empty: got %b, required 1", fifo_empty); else checks_passed++;
                if (tx_busy !== 1'b1) $display("[TB] FAIL flush_busy: got %b, required 1", tx_busy); else checks_passed++;
            end
        join
        repeat (100) @(negedge clk);
        checks_total++;
        if (tx_busy !== 1'b0) $display("[TB] FAIL flush_no_more: got %b, required 0", tx_busy); else checks_passed++;
    endtask

    task automatic test_reset_mid();
        int d0;
        set_fmt(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        push_byte(8'hA5, 1'b0);
        push_byte(8'h3C, 1'b0);
        repeat (100) @(negedge clk);
        d0 = done_cnt;
        #2;
        resetn = 1'b0;
        #1;
        checks_total += 5;
        if (txd !== 1'b1) $display("[TB] FAIL rmid_txd: got %b, required 1", txd); else checks_passed++;
        if (tx_busy !== 1'b0) $display("[TB] FAIL rmid_busy: got %b, required 0", tx_busy); else checks_passed++;
        if (tx_bclk_en !== 1'b0) $display("[TB] FAIL rmid_bclk_en: got %b, required 0", tx_bclk_en); else checks_passed++;
        if (fifo_level !== '0) $display("[TB] FAIL rmid_level: got %0d, required 0", fifo_level); else checks_passed++;
        if (fifo_empty !== 1'b1) $display("[TB] FAIL rmid_empty: got %b, required 1", fifo_empty); else checks_passed++;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (400) @(negedge clk);
        checks_total += 3;
        if (done_cnt !== d0) $display("[TB] FAIL rmid_done: got %0d pulses, required 0", done_cnt - d0); else checks_passed++;
        if (tx_busy !== 1'b0) $display("[TB] FAIL rmid_idle: got %b, required 0", tx_busy); else checks_passed++;
        if (txd !== 1'b1) $display("[TB] FAIL rmid_line: got %b, required 1", txd); else checks_passed++;
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_7e2();
        test_parity();
        test_break();
        test_push_gating();
        test_overflow();
        test_threshold_flush();
        test_reset_mid();
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
